mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences the single-ported RAM between the instruction-cache and data-cache request paths behind datapath_cache_if.
- Grants one requester at a time through a small FSM.
- Data has priority; a bounded starvation counter guarantees instruction progress.
- Flags RAM errors and access timeouts, and returns completion handshakes (wait/load) to each cache.

Parameters:
- DATA_W, 32, width of address, load and store words.
- STARVE_MAX, 4, max consecutive data grants while iREN is held before the instruction side is forced in.
- TIMEOUT, 255, max cycles in an access state without ramstate==ACCESS before abort.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- nRST  in  1  synchronous active-low reset.
- iREN  in  1  instruction read request, held until iwait=0.
- iaddr  in  DATA_W  instruction address.
- iwait  out  1  1 = instruction request not complete.
- iload  out  DATA_W  instruction read data, valid when iwait=0.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both high.
- daddr  in  DATA_W  data address.
- dstore  in  DATA_W  data write value.
- dwait  out  1  1 = data request not complete.
- dload  out  DATA_W  data read value, valid when dwait=0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  DATA_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- err  out  1  sticky error flag.

Behaviour:
- Reset (nRST low at a posedge): state=IDLE, starve_cnt=0, tmo_cnt=0, err=0.
- Outputs while in IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
- A reset mid-access aborts the access with no completion pulse.
- States: IDLE, I_ACC, D_ACC.
- IDLE arbitration, registered and evaluated each cycle:
  - D_ACC if (dREN|dWEN) and (!iREN or starve_cnt<STARVE_MAX).
  - Else I_ACC if iREN.
  - Else stay in IDLE.
- I_ACC: ramREN=1, ramaddr=iaddr. ramWEN=0.
- D_ACC: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN.
- RAM drive signals are combinational from the current state and the granted requester's inputs.
- Completion: in an access state with ramstate==ACCESS:
  - The granted wait goes 0 for exactly that cycle.
  - The granted load = ramload (dload=0 on writes).
  - Next state = IDLE.
- Minimum latency: request seen in IDLE at cycle N, completion at cycle N+1. Back-to-back grants therefore cost 2 cycles each.
- BUSY/FREE in an access state: hold the state; tmo_cnt increments (saturating); the wait stays 1.
- ERROR in an access state:
  - Complete the transaction: wait=0, load=32'hBAD1BAD1.
  - err<=1. Next state = IDLE.
- Timeout: tmo_cnt==TIMEOUT-1 without ACCESS:
  - Completes the same way as ERROR (wait=0, load=32'hBAD1BAD1, err<=1).
  - tmo_cnt clears on every state entry.
- Request withdrawal: if the granted request drops while in its access state:
  - Deassert the RAM enables that cycle and return to IDLE.
  - No completion pulse; starve_cnt unchanged.
- Starvation counter:
  - On a data completion with iREN=1, starve_cnt increments (saturates at STARVE_MAX).
  - Cleared on an instruction completion or whenever iREN=0 in IDLE.
- The non-granted requester always sees wait=1 and load=0.
- err clears only on reset.
- Same-cycle dWEN & dREN is treated as a write.

Decomposition:
- ramstate_t enum (FREE/BUSY/ACCESS/ERROR) goes in cpu_types_pkg; it is shared with the RAM model and the caches.
- arb_state_t enum and the ERR_WORD constant 32'hBAD1BAD1 go in a new mem_arbiter_pkg.
- Single module; no sub-module is warranted. The timeout and starvation counters are inline.

Test Plan:
- Instruction-only read: iREN=1, iaddr=0x40, RAM returns ACCESS on the first access cycle with ramload=0x2002_0001 -> iwait=0 one cycle later, iload=0x2002_0001, ramREN=1, ramWEN=0.
- Simultaneous request: iREN=1 and dWEN=1 (daddr=0x80, dstore=0xDEAD_BEEF) in IDLE -> D_ACC first (ramWEN=1, ramstore=0xDEAD_BEEF), dwait=0 on completion, then I_ACC; iwait is 1 throughout the data access.
- Starvation: iREN held; dREN reasserted immediately after each completion -> exactly 4 data completions, then an instruction grant; starve_cnt reads 0 after the instruction completes.
- Wait states and timeout: ramstate=BUSY for 3 cycles then ACCESS -> completion on the 4th access cycle with err=0. ramstate=BUSY forever -> completion after 255 access cycles, iload=0xBAD1BAD1, err=1 and it stays 1.
- RAM error: ramstate=ERROR during D_ACC read -> dwait=0, dload=0xBAD1BAD1, err=1, back to IDLE next cycle.
- Withdrawal and reset: dREN dropped in the second D_ACC cycle -> no dwait=0 pulse, IDLE next cycle. nRST=0 at a posedge during I_ACC -> all outputs at their reset values the following cycle, with no completion.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: types shared by the RAM model, the caches and the memory arbiter
package cpu_types_pkg;

    // RAM status reported to the arbiter every cycle
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: arbiter FSM states and the word returned on failed accesses
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } arb_state_t;

    localparam logic [31:0] ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction and data cache paths
//   CLK, nRST                        clock, synchronous active-low reset
//   iREN, iaddr -> iwait, iload       instruction read request / completion
//   dREN, dWEN, daddr, dstore -> dwait, dload   data request / completion
//   ramREN, ramWEN, ramaddr, ramstore <- ramload, ramstate   RAM side
//   err                              sticky RAM error / timeout flag
module mem_arbiter
    import cpu_types_pkg::*;
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [DATA_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [DATA_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [DATA_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
    output logic              err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t        r_state, w_next;
    logic [SW-1:0]     r_starve;
    logic [TW-1:0]     r_tmo;
    logic              r_err;
    logic              w_act, w_fail, w_done, w_dsel;
    logic [DATA_W-1:0] w_rd;

    always_comb begin
        // the granted requester still holds its request; otherwise the access is withdrawn
        w_act    = (r_state == I_ACC && iREN) || (r_state == D_ACC && (dREN || dWEN));
        w_fail   = w_act && (ramstate == ERROR || (ramstate != ACCESS && r_tmo == TW'(TIMEOUT - 1)));
        w_done   = w_act && (ramstate == ACCESS || w_fail);
        w_rd     = w_fail ? DATA_W'(ERR_WORD) : ramload;
        // data wins unless the instruction side has been passed over STARVE_MAX times
        w_dsel   = (dREN || dWEN) && (!iREN || r_starve < SW'(STARVE_MAX));
        w_next   = (r_state == IDLE) ? (w_dsel ? D_ACC : iREN ? I_ACC : IDLE)
                 : (!w_act || w_done) ? IDLE : r_state;
        ramREN   = (r_state == I_ACC && iREN) || (r_state == D_ACC && dREN && !dWEN);
        ramWEN   = r_state == D_ACC && dWEN;
        ramaddr  = (r_state == I_ACC) ? iaddr : (r_state == D_ACC) ? daddr : '0;
        ramstore = (r_state == D_ACC) ? dstore : '0;
        iwait    = !(w_done && r_state == I_ACC);
        dwait    = !(w_done && r_state == D_ACC);
        iload    = (w_done && r_state == I_ACC) ? w_rd : '0;
        dload    = (w_done && r_state == D_ACC && (w_fail || !dWEN)) ? w_rd : '0;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_starve <= '0;
            r_tmo    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_tmo    <= (r_state == IDLE || w_next != r_state) ? '0 : r_tmo + TW'(r_tmo != '1);
            r_err    <= r_err | w_fail;
            r_starve <= (w_done && r_state == I_ACC) ? '0
                      : (w_done && r_state == D_ACC && iREN) ? r_starve + SW'(r_starve != SW'(STARVE_MAX))
                      : (r_state == IDLE && !iREN) ? '0 : r_starve;
        end
    end

    assign err = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized checking of mem_arbiter against a cycle-level reference model
module tb_mem_arbiter;
    import cpu_types_pkg::*;
    import mem_arbiter_pkg::*;

    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int TMO  = 255;

    logic          CLK = 1'b0, nRST = 1'b0, iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [DW-1:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    ramstate_t     ramstate = FREE;
    logic          iwait, dwait, ramREN, ramWEN, err;
    logic [DW-1:0] iload, dload, ramaddr, ramstore;

    int checks = 0, errors = 0;
    int m_grant = 0, m_age = 0, m_starve = 0;
    bit m_err = 1'b0;
    logic          s_iwait, s_dwait, s_ren, s_wen, s_err;
    logic [DW-1:0] s_iload, s_dload, s_addr, s_store;

    always #5 CLK = ~CLK;

    mem_arbiter #(.DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: compare DUT against the model mid-cycle, then advance the model
    task automatic cyc();
        bit            act, done, bad;
        logic [DW-1:0] rd;
        @(negedge CLK);
        {s_iwait, s_dwait, s_ren, s_wen, s_err} = {iwait, dwait, ramREN, ramWEN, err};
        {s_iload, s_dload, s_addr, s_store} = {iload, dload, ramaddr, ramstore};
        act  = (m_grant == 1 && iREN) || (m_grant == 2 && (dREN || dWEN));
        bad  = act && (ramstate == ERROR || (ramstate != ACCESS && m_age + 1 == TMO));
        done = act && (ramstate == ACCESS || bad);
        rd   = bad ? ERR_WORD : ramload;
        check("iwait", iwait, !(done && m_grant == 1));
        check("dwait", dwait, !(done && m_grant == 2));
        check("iload", iload, (done && m_grant == 1) ? rd : 0);
        check("dload", dload, (done && m_grant == 2 && (bad || !dWEN)) ? rd : 0);
        check("ren", ramREN, (m_grant == 1 && iREN) || (m_grant == 2 && dREN && !dWEN));
        check("wen", ramWEN, m_grant == 2 && dWEN);
        check("addr", ramaddr, m_grant == 1 ? iaddr : m_grant == 2 ? daddr : 0);
        check("store", ramstore, m_grant == 2 ? dstore : 0);
        check("err", err, m_err);
        check("starve", dut.r_starve, m_starve);
        if (!nRST) begin
            m_grant = 0; m_age = 0; m_starve = 0; m_err = 0;
        end else if (m_grant == 0) begin
            m_grant = ((dREN || dWEN) && (!iREN || m_starve < SMAX)) ? 2 : iREN ? 1 : 0;
            if (!iREN) m_starve = 0;
            m_age = 0;
        end else if (!act || done) begin
            if (done && m_grant == 1) m_starve = 0;
            else if (done && iREN) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
            m_err   = m_err | bad;
            m_grant = 0;
            m_age   = 0;
        end else m_age++;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int n, nd;
        cyc(); cyc();
        check("rst_out", {s_iwait, s_dwait, s_ren, s_wen, s_err}, 5'b11000);
        nRST = 1'b1;
        // instruction-only read
        iREN = 1; iaddr = 'h40; ramstate = ACCESS; ramload = 'h2002_0001;
        cyc(); cyc();
        check("i_read", {s_iwait, s_ren, s_wen, s_iload}, {3'b010, 32'h2002_0001});
        iREN = 0; cyc();
        // simultaneous: data write goes first
        iREN = 1; dWEN = 1; daddr = 'h80; dstore = 'hDEAD_BEEF; ramload = 'h1234_5678;
        cyc(); cyc();
        check("d_first", {s_dwait, s_iwait, s_wen, s_store, s_dload}, {3'b011, 32'hDEAD_BEEF, 32'h0});
        dWEN = 0; cyc(); cyc();
        check("i_second", {s_iwait, s_iload}, {1'b0, 32'h1234_5678});
        iREN = 0; cyc();
        // starvation: data always pending while iREN is held
        iREN = 1; dREN = 1; nd = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (!s_dwait) nd++;
            if (!s_iwait) break;
        end
        check("starve_n", nd, SMAX);
        check("starve_clr", dut.r_starve, 0);
        iREN = 0; dREN = 0; cyc();
        // three wait states then ACCESS
        iREN = 1; ramstate = BUSY; cyc();
        repeat (3) cyc();
        ramstate = ACCESS; cyc();
        check("wait3", {s_iwait, s_err}, 2'b00);
        iREN = 0; cyc();
        // timeout
        iREN = 1; ramstate = BUSY; cyc(); n = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(); n++;
            if (!s_iwait) break;
        end
        check("tmo_n", n, TMO);
        check("tmo_load", s_iload, 32'hBAD1_BAD1);
        check("tmo_err", err, 1);
        iREN = 0; repeat (3) cyc();
        check("err_sticky", err, 1);
        nRST = 0; cyc(); nRST = 1;
        // RAM error on a data read
        dREN = 1; ramstate = ERROR; cyc(); cyc();
        check("rerr", {s_dwait, s_dload}, {1'b0, 32'hBAD1_BAD1});
        check("rerr_flag", err, 1);
        cyc();
        check("rerr_idle", {s_dwait, s_ren}, 2'b10);
        dREN = 0; cyc();
        nRST = 0; cyc(); nRST = 1;
        // withdrawal in the second data cycle
        dREN = 1; ramstate = BUSY; daddr = 'h99; cyc(); cyc();
        dREN = 0; ramstate = ACCESS; cyc();
        check("wd", {s_dwait, s_ren}, 2'b10);
        cyc();
        check("wd_idle", s_addr, 0);
        // reset in the middle of an instruction access
        iREN = 1; ramstate = BUSY; cyc(); cyc();
        nRST = 0; cyc();
        nRST = 1; ramstate = ACCESS; cyc();
        check("rst_mid", {s_iwait, s_ren, s_iload}, {2'b10, 32'h0});
        iREN = 0; cyc();
        // randomized traffic
        repeat (4000) begin
            if ($urandom_range(0, 9) == 0) iREN = ~iREN;
            if ($urandom_range(0, 9) == 0) dREN = ~dREN;
            if ($urandom_range(0, 14) == 0) dWEN = ~dWEN;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            n = $urandom_range(0, 9);
            ramstate = n < 4 ? ACCESS : n < 7 ? BUSY : n < 9 ? FREE : ERROR;
            nRST = $urandom_range(0, 199) != 0;
            cyc();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
